// File: rtl/logic_reduce_pipe.sv
// rtl/logic_reduce_pipe.sv - two-stage elastic N-operand AND/OR/XOR reduce unit with inversion and enable mask
module logic_reduce_pipe #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 6,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_en,
    input  logic [2:0]              in_op,
    input  logic                    flush,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_zero,
    output logic                    out_ones,
    output logic [CNT_W-1:0]        out_count
);
    localparam int NG = (NUM_IN + 2) / 3;
    localparam logic [1:0] F_AND = 2'd0;
    localparam logic [1:0] F_OR  = 2'd1;
    localparam logic [1:0] F_XOR = 2'd2;

    function automatic logic [WIDTH-1:0] ident(input logic [1:0] f);
        return (f == F_AND) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
    endfunction

    function automatic logic [WIDTH-1:0] combine(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic [1:0] f);
        case (f)
            F_AND:   return a & b;
            F_OR:    return a | b;
            default: return a ^ b;
        endcase
    endfunction

    logic                  s1_valid_q, s1_valid_d;
    logic [NG*WIDTH-1:0]   s1_part_q, s1_part_d;
    logic [1:0]            s1_func_q, s1_func_d;
    logic                  s1_inv_q, s1_inv_d;
    logic                  s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0]      out_data_q, out_data_d;
    logic                  out_zero_q, out_zero_d;
    logic                  out_ones_q, out_ones_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic                  s2_load, s1_load, in_fire;
    logic [NUM_IN-1:0]     en_eff;
    logic [NG*3-1:0]       en_pad;
    logic [NG*3*WIDTH-1:0] data_pad;
    logic [WIDTH-1:0]      acc, res;

    assign s2_load  = !s2_valid_q || out_ready;
    assign s1_load  = !s1_valid_q || s2_load;
    assign in_ready = !flush && s1_load;
    assign in_fire  = in_valid && in_ready;

    // Pass/NOT reuse the OR datapath with only channel 0 enabled.
    always_comb begin
        s1_func_d = (in_op[1:0] == 2'b11) ? F_OR : in_op[1:0];
        s1_inv_d  = in_op[2];
        en_eff    = (in_op[1:0] == 2'b11) ? {{(NUM_IN-1){1'b0}}, 1'b1} : in_en;
        en_pad    = '0;
        en_pad[NUM_IN-1:0] = en_eff;
        data_pad  = '0;
        data_pad[NUM_IN*WIDTH-1:0] = in_data;
        s1_part_d = '0;
        acc       = '0;
        for (int g = 0; g < NG; g++) begin
            acc = ident(s1_func_d);
            for (int k = 0; k < 3; k++) begin
                if (en_pad[g*3+k])
                    acc = combine(acc, data_pad[(g*3+k)*WIDTH +: WIDTH], s1_func_d);
            end
            s1_part_d[g*WIDTH +: WIDTH] = acc;
        end
    end

    always_comb begin
        res = ident(s1_func_q);
        for (int g = 0; g < NG; g++)
            res = combine(res, s1_part_q[g*WIDTH +: WIDTH], s1_func_q);
        if (s1_inv_q)
            res = ~res;

        s1_valid_d = s1_valid_q;
        s2_valid_d = s2_valid_q;
        out_data_d = out_data_q;
        out_zero_d = out_zero_q;
        out_ones_d = out_ones_q;
        cnt_d      = cnt_q;

        if (s1_load)
            s1_valid_d = in_fire;
        if (s2_load) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_data_d = res;
                out_zero_d = (res == '0);
                out_ones_d = (res == {WIDTH{1'b1}});
            end
        end
        if (s2_valid_q && out_ready && !flush)
            cnt_d = cnt_q + 1'b1;
        if (flush) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_part_q  <= '0;
            s1_func_q  <= '0;
            s1_inv_q   <= 1'b0;
            s2_valid_q <= 1'b0;
            out_data_q <= '0;
            out_zero_q <= 1'b0;
            out_ones_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            out_data_q <= out_data_d;
            out_zero_q <= out_zero_d;
            out_ones_q <= out_ones_d;
            cnt_q      <= cnt_d;
            if (in_fire) begin
                s1_part_q <= s1_part_d;
                s1_func_q <= s1_func_d;
                s1_inv_q  <= s1_inv_d;
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign out_data  = out_data_q;
    assign out_zero  = out_zero_q;
    assign out_ones  = out_ones_q;
    assign out_count = cnt_q;
endmodule

// File: tb/tb_logic_reduce_pipe.sv
// tb/tb_logic_reduce_pipe.sv - directed-vector bench for logic_reduce_pipe
module tb_logic_reduce_pipe;
    localparam int WIDTH  = 32;
    localparam int NUM_IN = 6;
    localparam int CNT_W  = 4;

    logic                    clk = 1'b0;
    logic                    reset = 1'b1;
    logic                    in_valid = 1'b0;
    logic                    in_ready;
    logic [NUM_IN*WIDTH-1:0] in_data = '0;
    logic [NUM_IN-1:0]       in_en = '0;
    logic [2:0]              in_op = '0;
    logic                    flush = 1'b0;
    logic                    out_valid;
    logic                    out_ready = 1'b0;
    logic [WIDTH-1:0]        out_data;
    logic                    out_zero;
    logic                    out_ones;
    logic [CNT_W-1:0]        out_count;

    int passed = 0;
    int total  = 0;

    logic_reduce_pipe #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_en(in_en), .in_op(in_op), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_zero(out_zero), .out_ones(out_ones), .out_count(out_count)
    );

    always #5 clk = ~clk;

    task automatic put(input logic [2:0] op, input logic [NUM_IN-1:0] en, input logic [31:0] d0);
        in_valid = 1'b1;
        in_op    = op;
        in_en    = en;
        in_data  = '0;
        in_data[31:0] = d0;
    endtask

    task automatic test_reset();
        #1;
        total++; if (out_valid !== 1'b0) $display("FAIL rst_valid got %0b want 0", out_valid); else passed++;
        total++; if (out_data !== 32'h0) $display("FAIL rst_data got %h want 0", out_data); else passed++;
        total++; if ({out_zero, out_ones} !== 2'b00) $display("FAIL rst_flags got %b want 00", {out_zero, out_ones}); else passed++;
        total++; if (out_count !== 4'd0) $display("FAIL rst_count got %0d want 0", out_count); else passed++;
        @(negedge clk);
        reset = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready got %0b want 1", in_ready); else passed++;
    endtask

    task automatic test_or();
        @(negedge clk);
        out_ready = 1'b1;
        put(3'b001, 6'h3F, 32'h1);
        for (int i = 1; i < NUM_IN; i++) in_data[i*WIDTH +: WIDTH] = 32'h1 << i;
        #1;
        total++; if (in_ready !== 1'b1) $display("FAIL or_in_ready got %0b want 1", in_ready); else passed++;
        @(negedge clk);
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b0) $display("FAIL or_latency got valid %0b want 0", out_valid); else passed++;
        @(negedge clk);
        total++; if (out_valid !== 1'b1 || out_data !== 32'h3F) $display("FAIL or_data got %0b/%h want 1/0000003f", out_valid, out_data); else passed++;
        total++; if ({out_zero, out_ones} !== 2'b00) $display("FAIL or_flags got %b want 00", {out_zero, out_ones}); else passed++;
        @(negedge clk);
        total++; if (out_count !== 4'd1 || out_valid !== 1'b0) $display("FAIL or_count got %0d/%0b want 1/0", out_count, out_valid); else passed++;
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        put(3'b000, 6'h00, 32'h1234);
        @(negedge clk);
        put(3'b010, 6'h00, 32'h1234);
        #1;
        total++; if (in_ready !== 1'b1) $display("FAIL b2b_in_ready got %0b want 1", in_ready); else passed++;
        @(negedge clk);
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || out_data !== 32'hFFFFFFFF || out_ones !== 1'b1 || out_zero !== 1'b0)
            $display("FAIL b2b_and got %0b/%h/%0b%0b want 1/ffffffff/z0o1", out_valid, out_data, out_zero, out_ones); else passed++;
        @(negedge clk);
        total++; if (out_valid !== 1'b1 || out_data !== 32'h0 || out_zero !== 1'b1 || out_ones !== 1'b0)
            $display("FAIL b2b_xor got %0b/%h/%0b%0b want 1/00000000/z1o0", out_valid, out_data, out_zero, out_ones); else passed++;
        @(negedge clk);
        total++; if (out_count !== 4'd3 || out_valid !== 1'b0) $display("FAIL b2b_count got %0d/%0b want 3/0", out_count, out_valid); else passed++;
    endtask

    task automatic test_xnor_not();
        @(negedge clk);
        put(3'b110, 6'b000011, 32'hA5A5A5A5);
        in_data[63:32] = 32'h5A5A5A5A;
        in_data[95:64] = 32'hFFFF0000;
        @(negedge clk);
        put(3'b111, 6'h00, 32'h0000FFFF);
        @(negedge clk);
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || out_data !== 32'h0 || out_zero !== 1'b1)
            $display("FAIL xnor got %0b/%h/z%0b want 1/00000000/z1", out_valid, out_data, out_zero); else passed++;
        @(negedge clk);
        total++; if (out_valid !== 1'b1 || out_data !== 32'hFFFF0000 || {out_zero, out_ones} !== 2'b00)
            $display("FAIL not0 got %0b/%h/%b want 1/ffff0000/00", out_valid, out_data, {out_zero, out_ones}); else passed++;
        @(negedge clk);
        total++; if (out_count !== 4'd5) $display("FAIL xnor_count got %0d want 5", out_count); else passed++;
    endtask

    task automatic test_stall();
        int sent, rcv, cyc;
        @(negedge clk);
        out_ready = 1'b0;
        put(3'b011, 6'h00, 32'h100);
        @(negedge clk);
        put(3'b011, 6'h00, 32'h101);
        @(negedge clk);
        put(3'b011, 6'h00, 32'h102);
        #1;
        total++; if (in_ready !== 1'b0) $display("FAIL stall_in_ready got %0b want 0", in_ready); else passed++;
        total++; if (out_valid !== 1'b1 || out_data !== 32'h100) $display("FAIL stall_head got %0b/%h want 1/00000100", out_valid, out_data); else passed++;
        @(negedge clk);
        #1;
        total++; if (out_data !== 32'h100 || in_ready !== 1'b0) $display("FAIL stall_hold got %h/%0b want 00000100/0", out_data, in_ready); else passed++;
        out_ready = 1'b1;
        sent = 2; rcv = 0; cyc = 0;
        while (rcv < 5 && cyc < 20) begin
            in_valid = (sent < 5);
            in_data[31:0] = 32'h100 + sent;
            #1;
            if (out_valid) begin
                total++; if (out_data !== 32'h100 + rcv) $display("FAIL stall_order[%0d] got %h want %h", rcv, out_data, 32'h100 + rcv); else passed++;
                rcv++;
            end
            if (in_valid && in_ready) sent++;
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        total++; if (rcv !== 5) $display("FAIL stall_drain got %0d results want 5", rcv); else passed++;
        total++; if (out_count !== 4'd10) $display("FAIL stall_count got %0d want 10", out_count); else passed++;
    endtask

    task automatic test_flush();
        @(negedge clk);
        out_ready = 1'b0;
        put(3'b011, 6'h00, 32'h200);
        @(negedge clk);
        put(3'b011, 6'h00, 32'h201);
        @(negedge clk);
        #1;
        total++; if (out_valid !== 1'b1) $display("FAIL flush_pre got valid %0b want 1", out_valid); else passed++;
        flush = 1'b1;
        out_ready = 1'b1;
        put(3'b011, 6'h00, 32'h202);
        #1;
        total++; if (in_ready !== 1'b0) $display("FAIL flush_in_ready got %0b want 0", in_ready); else passed++;
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0 || out_count !== 4'd10) $display("FAIL flush_post got %0b/%0d want 0/10", out_valid, out_count); else passed++;
        @(negedge clk);
        total++; if (out_valid !== 1'b0) $display("FAIL flush_s1 got valid %0b want 0", out_valid); else passed++;
    endtask

    task automatic test_wrap();
        int sent, rcv, cyc;
        @(negedge clk);
        reset = 1'b1;
        #2;
        reset = 1'b0;
        out_ready = 1'b1;
        sent = 0; rcv = 0; cyc = 0;
        while (rcv < 17 && cyc < 40) begin
            in_valid = (sent < 17);
            in_op = 3'b011;
            in_data[31:0] = 32'h300 + sent;
            #1;
            if (out_valid) begin
                total++; if (out_data !== 32'h300 + rcv) $display("FAIL wrap_order[%0d] got %h want %h", rcv, out_data, 32'h300 + rcv); else passed++;
                rcv++;
            end
            if (in_valid && in_ready) sent++;
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        total++; if (cyc !== 19) $display("FAIL wrap_throughput got %0d cycles want 19", cyc); else passed++;
        total++; if (out_count !== 4'd1) $display("FAIL wrap_count got %0d want 1", out_count); else passed++;
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        out_ready = 1'b0;
        put(3'b000, 6'h00, 32'h0);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        total++; if (out_valid !== 1'b1 || out_ones !== 1'b1) $display("FAIL areset_pre got %0b/o%0b want 1/o1", out_valid, out_ones); else passed++;
        reset = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0 || out_data !== 32'h0) $display("FAIL areset_out got %0b/%h want 0/00000000", out_valid, out_data); else passed++;
        total++; if ({out_zero, out_ones} !== 2'b00 || out_count !== 4'd0) $display("FAIL areset_flags got %b/%0d want 00/0", {out_zero, out_ones}, out_count); else passed++;
        #1;
        reset = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1) $display("FAIL areset_in_ready got %0b want 1", in_ready); else passed++;
    endtask

    initial begin
        test_reset();
        test_or();
        test_back_to_back();
        test_xnor_not();
        test_stall();
        test_flush();
        test_wrap();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
